// File: rtl/mux_arbiter.sv
// Two-source arbiter driving a data mux. Grants are registered and one-hot
// or zero. A hold counter limits how many accepted beats one source may take
// while the other source waits. A LAST flag breaks ties toward the source
// that was not released most recently.
module mux_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int WIDTH    = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ_1,
  input  logic             REQ_2,
  input  logic [WIDTH-1:0] DATA_1,
  input  logic [WIDTH-1:0] DATA_2,
  input  logic             ACK_IN,
  output logic             GNT_1,
  output logic             GNT_2,
  output logic             MUXSELECT,
  output logic [WIDTH-1:0] OUTMUX,
  output logic             OUTVALID
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  // The counter value at which the next beat reaches the hold limit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT1 = 2'd1;
  localparam logic [1:0] GRANT2 = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  // 1 means source 2 was the last one released, 0 means source 1.
  logic             last_two_r;
  logic             last_two_next_s;
  logic             gnt_1_r;
  logic             gnt_2_r;
  logic             msel_r;
  logic             msel_next_s;
  logic             beat_s;
  logic             own_req_s;
  logic             oth_req_s;
  logic [1:0]       oth_state_s;
  logic             own_is_two_s;

  assign GNT_1     = gnt_1_r;
  assign GNT_2     = gnt_2_r;
  assign MUXSELECT = msel_r;
  assign OUTVALID  = (gnt_1_r & REQ_1) | (gnt_2_r & REQ_2);
  assign OUTMUX    = msel_r ? DATA_1 : DATA_2;
  assign beat_s    = OUTVALID & ACK_IN;

  // Identify the owning and the waiting requester for the current grant state.
  always_comb begin
    own_req_s    = 1'b0;
    oth_req_s    = 1'b0;
    oth_state_s  = IDLE;
    own_is_two_s = 1'b0;
    if (state_r == GRANT2) begin
      own_req_s    = REQ_2;
      oth_req_s    = REQ_1;
      oth_state_s  = GRANT1;
      own_is_two_s = 1'b1;
    end else begin
      own_req_s    = REQ_1;
      oth_req_s    = REQ_2;
      oth_state_s  = GRANT2;
      own_is_two_s = 1'b0;
    end
  end

  // Next-state, hold counter and LAST flag decisions.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    last_two_next_s = last_two_r;
    case (state_r)
      IDLE: begin
        cnt_next_s = CNT_ZERO;
        if (REQ_1 && REQ_2) begin
          state_next_s = last_two_r ? GRANT1 : GRANT2;
        end else if (REQ_1) begin
          state_next_s = GRANT1;
        end else if (REQ_2) begin
          state_next_s = GRANT2;
        end else begin
          state_next_s = IDLE;
        end
      end
      GRANT1, GRANT2: begin
        if (!own_req_s) begin
          // Owner released: hand over directly if the other side is waiting.
          state_next_s    = oth_req_s ? oth_state_s : IDLE;
          last_two_next_s = own_is_two_s;
          cnt_next_s      = CNT_ZERO;
        end else if (beat_s) begin
          if (cnt_r == CNT_LAST) begin
            // Hold limit reached: yield only when someone else wants the mux.
            cnt_next_s = CNT_ZERO;
            if (oth_req_s) begin
              state_next_s    = oth_state_s;
              last_two_next_s = own_is_two_s;
            end else begin
              state_next_s    = state_r;
            end
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end else begin
          // No accepted beat: everything holds, waiting requester cannot preempt.
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // Select follows the granted source and holds its value while idle.
  always_comb begin
    msel_next_s = msel_r;
    if (state_next_s == GRANT1) begin
      msel_next_s = 1'b1;
    end else if (state_next_s == GRANT2) begin
      msel_next_s = 1'b0;
    end else begin
      msel_next_s = msel_r;
    end
  end

  // State and registered outputs, with synchronous reset overriding everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      last_two_r <= 1'b1;
      gnt_1_r    <= 1'b0;
      gnt_2_r    <= 1'b0;
      msel_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      last_two_r <= last_two_next_s;
      gnt_1_r    <= (state_next_s == GRANT1);
      gnt_2_r    <= (state_next_s == GRANT2);
      msel_r     <= msel_next_s;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios followed by random
// traffic, all compared against an owner/count/last reference model.
module tb_mux_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int WIDTH    = 8;

  logic             clk;
  logic             rst;
  logic             req_1;
  logic             req_2;
  logic [WIDTH-1:0] data_1;
  logic [WIDTH-1:0] data_2;
  logic             ack_in;
  logic             gnt_1;
  logic             gnt_2;
  logic             muxselect;
  logic [WIDTH-1:0] outmux;
  logic             outvalid;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: owner 0 = nobody, 1 = source 1, 2 = source 2.
  int   m_owner;
  int   m_cnt;
  int   m_last;
  logic m_msel;

  mux_arbiter #(.MAX_HOLD(MAX_HOLD), .WIDTH(WIDTH)) dut (
    .CLK(clk), .RESET(rst), .REQ_1(req_1), .REQ_2(req_2),
    .DATA_1(data_1), .DATA_2(data_2), .ACK_IN(ack_in),
    .GNT_1(gnt_1), .GNT_2(gnt_2), .MUXSELECT(muxselect),
    .OUTMUX(outmux), .OUTVALID(outvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int   other;
    logic own_req;
    logic oth_req;
    logic valid;
    if (rst) begin
      m_owner = 0; m_cnt = 0; m_last = 2; m_msel = 1'b0;
    end else begin
      if (m_owner == 0) begin
        m_cnt = 0;
        if (req_1 && req_2) m_owner = (m_last == 1) ? 2 : 1;
        else if (req_1)     m_owner = 1;
        else if (req_2)     m_owner = 2;
      end else begin
        other   = 3 - m_owner;
        own_req = (m_owner == 1) ? req_1 : req_2;
        oth_req = (m_owner == 1) ? req_2 : req_1;
        valid   = own_req;
        if (!own_req) begin
          m_last  = m_owner;
          m_cnt   = 0;
          m_owner = oth_req ? other : 0;
        end else if (valid && ack_in) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == MAX_HOLD) begin
            m_cnt = 0;
            if (oth_req) begin
              m_last  = m_owner;
              m_owner = other;
            end
          end
        end
      end
      if (m_owner == 1)      m_msel = 1'b1;
      else if (m_owner == 2) m_msel = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then cross the edge.
  task automatic run_cycle(input logic r, input logic r1, input logic r2, input logic ack,
                           input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2);
    logic exp_valid;
    rst = r; req_1 = r1; req_2 = r2; ack_in = ack; data_1 = d1; data_2 = d2;
    @(negedge clk);
    exp_valid = ((m_owner == 1) && r1) || ((m_owner == 2) && r2);
    check_val("gnt_1", 32'(gnt_1), 32'(m_owner == 1));
    check_val("gnt_2", 32'(gnt_2), 32'(m_owner == 2));
    check_val("gnt_excl", 32'(gnt_1 & gnt_2), 32'd0);
    check_val("muxselect", 32'(muxselect), 32'(m_msel));
    check_val("outvalid", 32'(outvalid), 32'(exp_valid));
    check_val("outmux", 32'(outmux), 32'(m_msel ? d1 : d2));
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_1 = 1'b0; req_2 = 1'b0; ack_in = 1'b0;
    data_1 = 8'h00; data_2 = 8'h00;
    m_owner = 0; m_cnt = 0; m_last = 2; m_msel = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with REQ_1 high, then one-cycle grant latency on release.
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h22);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h22);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h22);
    check_val("rel_gnt_1", 32'(gnt_1), 32'd1);
    check_val("rel_msel", 32'(muxselect), 32'd1);

    // Both requesting with ACK: alternating bursts of MAX_HOLD beats.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'hA1, 8'h0F);
    for (int i = 0; i < 18; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 8'h0F);

    // ACK low for 10 cycles in GRANT1 with REQ_2 waiting, then resume.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 8'hC3);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'hC3);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'hC3);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 8'hC3);
    check_val("ackhold_gnt_1", 32'(gnt_1), 32'd1);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 8'hC3);

    // REQ_1 drops after two beats while REQ_2 waits: direct handover.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h02);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h02);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h02);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h02);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h02);
    check_val("drop_gnt_2", 32'(gnt_2), 32'd1);
    check_val("drop_msel", 32'(muxselect), 32'd0);

    // Lone REQ_2 keeps its grant across counter wraps.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 8'h44);
    for (int i = 0; i < 11; i++) run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 8'h44);

    // Reset in GRANT2 at count 3, then both request: source 1 wins.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h66, 8'h77);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 8'h77);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 8'h77);
    check_val("rst_gnt_2", 32'(gnt_2), 32'd0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h66, 8'h77);
    check_val("rst_then_gnt_1", 32'(gnt_1), 32'd1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      run_cycle(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0),
                WIDTH'($urandom), WIDTH'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive accepted beats per grant while the other requester waits (legal range 1..255).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the data width.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 REQ_1, REQ_2  input  1 each  request from source 1 / source 2.
REQ-006 DATA_1, DATA_2  input  WIDTH each  source operands.
REQ-007 ACK_IN  input  1  consumer accepts the current beat.
REQ-008 GNT_1, GNT_2  output  1 each  registered grant, one-hot or zero.
REQ-009 MUXSELECT  output  1  registered select: 1 = DATA_1, 0 = DATA_2.
REQ-010 OUTMUX  output  WIDTH  combinational: DATA_1 when MUXSELECT=1, else DATA_2.
REQ-011 OUTVALID  output  1  combinational: (GNT_1 & REQ_1) | (GNT_2 & REQ_2).

Function
REQ-012 The FSM SHALL have three states: IDLE, GRANT1, GRANT2; GNT_1=1 only in GRANT1, GNT_2=1 only in GRANT2.
REQ-013 MUXSELECT SHALL be 1 in GRANT1, 0 in GRANT2, and hold its last value in IDLE.
REQ-014 A beat SHALL occur on any edge where OUTVALID=1 and ACK_IN=1; a beat increments a hold counter CNT of width clog2(MAX_HOLD+1).
REQ-015 The block SHALL keep a LAST flag recording the last source released (1 or 2).
REQ-016 IDLE: only REQ_1 -> GRANT1; only REQ_2 -> GRANT2; both -> grant the source not equal to LAST; neither -> stay; CNT=0 on any grant.
REQ-017 GRANTx with REQ_x=0 -> GRANT(other) if REQ_other=1, else IDLE; LAST=x; CNT=0.
REQ-018 GRANTx, beat with CNT+1=MAX_HOLD and REQ_other=1 -> GRANT(other) on the same edge, no idle cycle; LAST=x; CNT=0.
REQ-019 GRANTx, beat with CNT+1=MAX_HOLD and REQ_other=0 -> stay in GRANTx; CNT=0.
REQ-020 GRANTx, any other case -> stay; CNT increments only on a beat.
REQ-021 With ACK_IN=0, GRANTx SHALL be held indefinitely; CNT, MUXSELECT and the grant SHALL not change, and a waiting requester SHALL not preempt.
REQ-022 Grant latency from IDLE SHALL be exactly one cycle from REQ sampled high to GNT high.
REQ-023 GNT_1 and GNT_2 SHALL never be high in the same cycle.

Reset
REQ-024 When RESET=1 at an edge, the block SHALL enter IDLE with GNT_1=0, GNT_2=0, MUXSELECT=0, CNT=0 and LAST=2, overriding all other inputs.
REQ-025 OUTVALID SHALL be 0 during reset because both grants are 0; OUTMUX follows DATA_2.
REQ-026 Reset asserted mid-grant SHALL abort the grant with no further beat.

Verification
REQ-027 RESET=1 for 2 cycles with REQ_1=1 -> GNT_1=0, GNT_2=0, OUTVALID=0, MUXSELECT=0; on the first edge after release -> GNT_1=1, MUXSELECT=1.
REQ-028 After reset, REQ_1=REQ_2=1, ACK_IN=1, DATA_1=8'hA1, DATA_2=8'h0F, MAX_HOLD=4 -> 4 beats with OUTMUX=8'hA1, then 4 beats with 8'h0F, alternating, OUTVALID continuously 1.
REQ-029 In GRANT1 with ACK_IN=0 for 10 cycles and REQ_2=1 -> GNT_1 stays 1 and OUTMUX stays DATA_1; ACK_IN=1 then resumes the count from its held value.
REQ-030 In GRANT1 after 2 beats, REQ_1 drops while REQ_2=1 -> next edge GNT_2=1, MUXSELECT=0, LAST=1.
REQ-031 Only REQ_2=1, ACK_IN=1 for 10 cycles -> GNT_2 held for all 10 beats, CNT wraps at 4, never IDLE.
REQ-032 RESET pulsed in GRANT2 with CNT=3 -> next edge IDLE; after release with both REQ=1 -> GNT_1 wins.
